// File: rtl/maze_move_ctrl.sv
// Player-sprite move sequencer: a tick proposes a step, four corner wall lookups gate the commit.
// Latency: tick in T -> wall_req T+1..T+4 (zero-wait ack), COMMIT T+5, new pos from T+6; ticks while busy are dropped.
module maze_move_ctrl #(
    parameter int START_X = 40,
    parameter int START_Y = 250,
    parameter int STEP    = 2,
    parameter int HALF    = 8,
    parameter int X_MAX   = 779,
    parameter int Y_MAX   = 479,
    parameter int GOAL_X  = 740
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        move_tick,
    input  logic        btn_u,
    input  logic        btn_d,
    input  logic        btn_l,
    input  logic        btn_r,
    output logic        wall_req,
    output logic [9:0]  wall_x,
    output logic [9:0]  wall_y,
    input  logic        wall_ack,
    input  logic        wall_hit,
    output logic [9:0]  pos_x,
    output logic [9:0]  pos_y,
    output logic [15:0] move_count,
    output logic        goal,
    output logic        busy
);
    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_TICK, S_CHECK, S_COMMIT, S_DONE
    } state_t;

    localparam logic signed [10:0] L_STEP = 11'(STEP);
    localparam logic signed [10:0] L_HALF = 11'(HALF);
    localparam logic signed [10:0] L_XMAX = 11'(X_MAX);
    localparam logic signed [10:0] L_YMAX = 11'(Y_MAX);
    localparam logic [9:0] L_START_X = 10'(START_X);
    localparam logic [9:0] L_START_Y = 10'(START_Y);
    localparam logic [9:0] L_GOAL_X  = 10'(GOAL_X);
    localparam logic [9:0] L_HALF10  = 10'(HALF);

    state_t      r_state, w_state_nxt;
    logic [9:0]  r_pos_x, r_pos_y, w_pos_x_nxt, w_pos_y_nxt;
    logic [9:0]  r_cand_x, r_cand_y, w_cand_x_nxt, w_cand_y_nxt;
    logic [1:0]  r_k, w_k_nxt;
    logic [15:0] r_count, w_count_nxt;
    logic        r_goal, w_goal_nxt;
    logic        r_wall_req, w_wall_req_nxt;
    logic        r_busy, w_busy_nxt;
    logic [9:0]  r_wall_x, r_wall_y, w_wall_x_nxt, w_wall_y_nxt;

    logic [2:0]         w_btn_cnt;
    logic signed [10:0] w_dx, w_dy, w_cx, w_cy;
    logic               w_in_bounds, w_move_ok;

    // Corner order: bit 0 selects the right edge, bit 1 the bottom edge.
    function automatic logic [9:0] corner_x(input logic [1:0] k, input logic [9:0] cx);
        return k[0] ? cx + L_HALF10 : cx - L_HALF10;
    endfunction

    function automatic logic [9:0] corner_y(input logic [1:0] k, input logic [9:0] cy);
        return k[1] ? cy + L_HALF10 : cy - L_HALF10;
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] res;
        logic        carry;
        res   = v;
        carry = 1'b1;
        if (v == 16'h9999) return v;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (res[i*4 +: 4] == 4'd9) begin
                    res[i*4 +: 4] = 4'd0;
                end else begin
                    res[i*4 +: 4] = res[i*4 +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        return res;
    endfunction

    always_comb begin
        w_btn_cnt = 3'(btn_u) + 3'(btn_d) + 3'(btn_l) + 3'(btn_r);
        w_dx = '0;
        w_dy = '0;
        if (btn_r)      w_dx = L_STEP;
        else if (btn_l) w_dx = -L_STEP;
        if (btn_d)      w_dy = L_STEP;
        else if (btn_u) w_dy = -L_STEP;
        w_cx = $signed({1'b0, r_pos_x}) + w_dx;
        w_cy = $signed({1'b0, r_pos_y}) + w_dy;
        w_in_bounds = !(((w_cx - L_HALF) < 11'sd0) || ((w_cx + L_HALF) > L_XMAX) ||
                        ((w_cy - L_HALF) < 11'sd0) || ((w_cy + L_HALF) > L_YMAX));
        w_move_ok = move_tick && (w_btn_cnt == 3'd1) && w_in_bounds;
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pos_x_nxt    = r_pos_x;
        w_pos_y_nxt    = r_pos_y;
        w_cand_x_nxt   = r_cand_x;
        w_cand_y_nxt   = r_cand_y;
        w_k_nxt        = r_k;
        w_count_nxt    = r_count;
        w_goal_nxt     = r_goal;
        w_wall_req_nxt = 1'b0;
        w_wall_x_nxt   = r_wall_x;
        w_wall_y_nxt   = r_wall_y;
        w_busy_nxt     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_pos_x_nxt = L_START_X;
                w_pos_y_nxt = L_START_Y;
                if (start) begin
                    w_state_nxt = S_WAIT_TICK;
                    w_count_nxt = '0;
                    w_goal_nxt  = 1'b0;
                end
            end
            S_WAIT_TICK: begin
                if (!start) begin
                    w_state_nxt = S_IDLE;
                    w_pos_x_nxt = L_START_X;
                    w_pos_y_nxt = L_START_Y;
                end else if (w_move_ok) begin
                    w_state_nxt    = S_CHECK;
                    w_cand_x_nxt   = w_cx[9:0];
                    w_cand_y_nxt   = w_cy[9:0];
                    w_k_nxt        = 2'd0;
                    w_wall_req_nxt = 1'b1;
                    w_wall_x_nxt   = corner_x(2'd0, w_cx[9:0]);
                    w_wall_y_nxt   = corner_y(2'd0, w_cy[9:0]);
                    w_busy_nxt     = 1'b1;
                end
            end
            S_CHECK: begin
                w_wall_req_nxt = 1'b1;
                w_busy_nxt     = 1'b1;
                if (wall_ack) begin
                    // A dropped start still lets the outstanding lookup finish, then abandons the move.
                    if (!start) begin
                        w_state_nxt    = S_IDLE;
                        w_wall_req_nxt = 1'b0;
                        w_busy_nxt     = 1'b0;
                        w_pos_x_nxt    = L_START_X;
                        w_pos_y_nxt    = L_START_Y;
                    end else if (wall_hit) begin
                        w_state_nxt    = S_WAIT_TICK;
                        w_wall_req_nxt = 1'b0;
                        w_busy_nxt     = 1'b0;
                    end else if (r_k == 2'd3) begin
                        w_state_nxt    = S_COMMIT;
                        w_wall_req_nxt = 1'b0;
                    end else begin
                        w_k_nxt      = r_k + 2'd1;
                        w_wall_x_nxt = corner_x(r_k + 2'd1, r_cand_x);
                        w_wall_y_nxt = corner_y(r_k + 2'd1, r_cand_y);
                    end
                end
            end
            S_COMMIT: begin
                w_pos_x_nxt = r_cand_x;
                w_pos_y_nxt = r_cand_y;
                w_count_nxt = bcd_inc(r_count);
                if (r_cand_x >= L_GOAL_X) begin
                    w_goal_nxt  = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_WAIT_TICK;
                end
            end
            S_DONE: begin
                if (!start) begin
                    w_state_nxt = S_IDLE;
                    w_pos_x_nxt = L_START_X;
                    w_pos_y_nxt = L_START_Y;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_pos_x    <= L_START_X;
            r_pos_y    <= L_START_Y;
            r_cand_x   <= '0;
            r_cand_y   <= '0;
            r_k        <= '0;
            r_count    <= '0;
            r_goal     <= 1'b0;
            r_wall_req <= 1'b0;
            r_wall_x   <= '0;
            r_wall_y   <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pos_x    <= w_pos_x_nxt;
            r_pos_y    <= w_pos_y_nxt;
            r_cand_x   <= w_cand_x_nxt;
            r_cand_y   <= w_cand_y_nxt;
            r_k        <= w_k_nxt;
            r_count    <= w_count_nxt;
            r_goal     <= w_goal_nxt;
            r_wall_req <= w_wall_req_nxt;
            r_wall_x   <= w_wall_x_nxt;
            r_wall_y   <= w_wall_y_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign wall_req   = r_wall_req;
    assign wall_x     = r_wall_x;
    assign wall_y     = r_wall_y;
    assign pos_x      = r_pos_x;
    assign pos_y      = r_pos_y;
    assign move_count = r_count;
    assign goal       = r_goal;
    assign busy       = r_busy;
endmodule

// File: tb/tb_maze_move_ctrl.sv
// Bench for maze_move_ctrl: reference model of pending corner lookups plus directed literal checks.
module tb_maze_move_ctrl;
    localparam int START_X = 40;
    localparam int START_Y = 250;
    localparam int STEP    = 2;
    localparam int HALF    = 8;
    localparam int X_MAX   = 779;
    localparam int Y_MAX   = 479;
    localparam int GOAL_X  = 740;

    logic        clk, reset, start, move_tick;
    logic        btn_u, btn_d, btn_l, btn_r;
    logic        wall_req, wall_ack, wall_hit, goal, busy;
    logic [9:0]  wall_x, wall_y, pos_x, pos_y;
    logic [15:0] move_count;

    int n_checks = 0;
    int n_errors = 0;
    int ack_wait = 0;
    int hit_on   = -1;

    maze_move_ctrl #(
        .START_X(START_X), .START_Y(START_Y), .STEP(STEP), .HALF(HALF),
        .X_MAX(X_MAX), .Y_MAX(Y_MAX), .GOAL_X(GOAL_X)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .move_tick(move_tick),
        .btn_u(btn_u), .btn_d(btn_d), .btn_l(btn_l), .btn_r(btn_r),
        .wall_req(wall_req), .wall_x(wall_x), .wall_y(wall_y),
        .wall_ack(wall_ack), .wall_hit(wall_hit),
        .pos_x(pos_x), .pos_y(pos_y), .move_count(move_count),
        .goal(goal), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int n);
        logic [15:0] r;
        r[15:12] = 4'((n / 1000) % 10);
        r[11:8]  = 4'((n / 100) % 10);
        r[7:4]   = 4'((n / 10) % 10);
        r[3:0]   = 4'(n % 10);
        return r;
    endfunction

    // Model: a move is a queue of corner lookups still owed, then one commit cycle.
    int  m_mode;   // 0 idle, 1 running, 2 at goal
    int  m_px, m_py, m_cnt, m_cx, m_cy;
    bit  m_goal, m_commit, m_valid = 0;
    int  qx[$];
    int  qy[$];

    always @(posedge clk) begin
        int nb, cx, cy;
        if (reset) begin
            m_valid = 1; m_mode = 0; m_px = START_X; m_py = START_Y;
            m_cnt = 0; m_goal = 0; m_commit = 0;
            qx.delete(); qy.delete();
        end else if (m_commit) begin
            m_commit = 0;
            m_px = m_cx; m_py = m_cy;
            if (m_cnt < 9999) m_cnt++;
            if (m_px >= GOAL_X) begin m_goal = 1; m_mode = 2; end
        end else if (qx.size() > 0) begin
            if (wall_ack) begin
                void'(qx.pop_front());
                void'(qy.pop_front());
                if (!start) begin
                    qx.delete(); qy.delete();
                    m_mode = 0; m_px = START_X; m_py = START_Y;
                end else if (wall_hit) begin
                    qx.delete(); qy.delete();
                end else if (qx.size() == 0) begin
                    m_commit = 1;
                end
            end
        end else if (m_mode == 0) begin
            m_px = START_X; m_py = START_Y;
            if (start) begin m_mode = 1; m_cnt = 0; m_goal = 0; end
        end else if (!start) begin
            m_mode = 0; m_px = START_X; m_py = START_Y;
        end else if (m_mode == 1 && move_tick) begin
            nb = int'(btn_u) + int'(btn_d) + int'(btn_l) + int'(btn_r);
            cx = m_px + (btn_r ? STEP : 0) - (btn_l ? STEP : 0);
            cy = m_py + (btn_d ? STEP : 0) - (btn_u ? STEP : 0);
            if (nb == 1 && cx - HALF >= 0 && cx + HALF <= X_MAX && cy - HALF >= 0 && cy + HALF <= Y_MAX) begin
                m_cx = cx; m_cy = cy;
                qx.push_back(cx - HALF); qy.push_back(cy - HALF);
                qx.push_back(cx + HALF); qy.push_back(cy - HALF);
                qx.push_back(cx - HALF); qy.push_back(cy + HALF);
                qx.push_back(cx + HALF); qy.push_back(cy + HALF);
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("m_wall_req", 32'(wall_req), 32'(qx.size() > 0));
            chk("m_busy", 32'(busy), 32'((qx.size() > 0) || m_commit));
            chk("m_pos_x", 32'(pos_x), m_px);
            chk("m_pos_y", 32'(pos_y), m_py);
            chk("m_move_count", 32'(move_count), 32'(to_bcd(m_cnt)));
            chk("m_goal", 32'(goal), 32'(m_goal));
            if (qx.size() > 0) begin
                chk("m_wall_x", 32'(wall_x), qx[0]);
                chk("m_wall_y", 32'(wall_y), qy[0]);
            end
        end
    end

    // Lookup responder: acks after ack_wait idle cycles; corner number hit_on reports a wall.
    initial begin
        int w, n;
        wall_ack = 1'b0; wall_hit = 1'b0; w = 0; n = 0;
        forever begin
            @(negedge clk);
            if (wall_req) begin
                if (w >= ack_wait) begin
                    wall_ack = 1'b1; wall_hit = (n == hit_on); w = 0; n++;
                end else begin
                    wall_ack = 1'b0; wall_hit = 1'b0; w++;
                end
            end else begin
                wall_ack = 1'b0; wall_hit = 1'b0; w = 0; n = 0;
            end
        end
    end

    task automatic pulse_tick();
        move_tick = 1'b1;
        @(negedge clk);
        move_tick = 1'b0;
    endtask

    task automatic watch(input int n, output int reqs);
        reqs = 0;
        for (int i = 0; i < n; i++) begin
            if (wall_req) reqs++;
            @(negedge clk);
        end
    endtask

    task automatic do_move(input logic [3:0] b, input int w);
        int r;
        ack_wait = w;
        {btn_u, btn_d, btn_l, btn_r} = b;
        pulse_tick();
        watch(4 * (w + 1) + 4, r);
        {btn_u, btn_d, btn_l, btn_r} = 4'b0000;
    endtask

    int exp_x[4] = '{34, 50, 34, 50};
    int exp_y[4] = '{242, 242, 258, 258};
    int rq, r2;

    initial begin
        reset = 1'b1; start = 1'b0; move_tick = 1'b0;
        btn_u = 1'b0; btn_d = 1'b0; btn_l = 1'b0; btn_r = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_pos_x", 32'(pos_x), 40);
        chk("rst_pos_y", 32'(pos_y), 250);
        chk("rst_count", 32'(move_count), 32'h0000);
        chk("rst_goal", 32'(goal), 0);
        chk("rst_wall_req", 32'(wall_req), 0);
        chk("rst_wall_x", 32'(wall_x), 0);
        chk("rst_busy", 32'(busy), 0);
        reset = 1'b0; start = 1'b1;
        repeat (2) @(negedge clk);

        // Zero-wait right move: cycle-exact latency.
        ack_wait = 0;
        btn_r = 1'b1;
        pulse_tick();
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) @(negedge clk);
            if (c <= 4) begin
                chk("r_req", 32'(wall_req), 1);
                chk("r_wall_x", 32'(wall_x), exp_x[c-1]);
                chk("r_wall_y", 32'(wall_y), exp_y[c-1]);
            end else if (c == 5) begin
                chk("r_req_low", 32'(wall_req), 0);
                chk("r_busy_commit", 32'(busy), 1);
                chk("r_pos_before", 32'(pos_x), 40);
            end else begin
                chk("r_pos_after", 32'(pos_x), 42);
                chk("r_count", 32'(move_count), 32'h0001);
            end
        end
        btn_r = 1'b0;
        @(negedge clk);

        // Wall on corner 1 with two wait cycles per lookup.
        ack_wait = 2; hit_on = 1; btn_u = 1'b1;
        pulse_tick();
        watch(16, rq);
        btn_u = 1'b0; hit_on = -1;
        chk("hit_req_cycles", rq, 6);
        chk("hit_pos_x", 32'(pos_x), 42);
        chk("hit_pos_y", 32'(pos_y), 250);
        chk("hit_count", 32'(move_count), 32'h0001);

        // Walk left to the edge; count passes 9 -> 10.
        for (int i = 1; i <= 17; i++) begin
            do_move(4'b0010, 0);
            if (i == 8) chk("bcd_9", 32'(move_count), 32'h0009);
            if (i == 9) chk("bcd_10", 32'(move_count), 32'h0010);
        end
        chk("left_edge_x", 32'(pos_x), 8);
        btn_l = 1'b1;
        pulse_tick();
        watch(8, rq);
        btn_l = 1'b0;
        chk("bound_no_req", rq, 0);
        chk("bound_pos_x", 32'(pos_x), 8);
        btn_l = 1'b1; btn_u = 1'b1;
        pulse_tick();
        watch(8, rq);
        btn_l = 1'b0; btn_u = 1'b0;
        chk("two_btn_no_req", rq, 0);
        chk("two_btn_pos_y", 32'(pos_y), 250);

        // Second tick while busy must be dropped.
        ack_wait = 0; btn_r = 1'b1;
        pulse_tick();
        @(negedge clk);
        pulse_tick();
        watch(10, rq);
        btn_r = 1'b0;
        chk("busy_tick_pos_x", 32'(pos_x), 10);
        chk("busy_tick_count", 32'(move_count), 32'h0019);

        // Run right to the goal column.
        for (int i = 0; i < 400 && pos_x < 10'd740; i++) begin
            if (pos_x == 10'd738) chk("goal_pre", 32'(goal), 0);
            do_move(4'b0001, 0);
        end
        chk("goal_pos_x", 32'(pos_x), 740);
        chk("goal_flag", 32'(goal), 1);
        chk("goal_count", 32'(move_count), 32'h0384);
        btn_l = 1'b1;
        pulse_tick();
        watch(8, rq);
        btn_l = 1'b0;
        chk("done_no_req", rq, 0);
        chk("done_pos_x", 32'(pos_x), 740);

        // Stop and restart clears the game.
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_pos_x", 32'(pos_x), 40);
        chk("idle_pos_y", 32'(pos_y), 250);
        start = 1'b1;
        repeat (2) @(negedge clk);
        chk("restart_goal", 32'(goal), 0);
        chk("restart_count", 32'(move_count), 32'h0000);

        // start dropped mid-lookup: that lookup completes, nothing commits.
        ack_wait = 3; btn_r = 1'b1;
        pulse_tick();
        rq = wall_req ? 1 : 0;
        @(negedge clk);
        start = 1'b0; btn_r = 1'b0;
        watch(12, r2);
        rq += r2;
        chk("drop_req_cycles", rq, 4);
        chk("drop_busy", 32'(busy), 0);
        chk("drop_count", 32'(move_count), 32'h0000);

        // Reset in the middle of a lookup.
        start = 1'b1;
        repeat (2) @(negedge clk);
        do_move(4'b0001, 0);
        chk("pre_rst_pos_x", 32'(pos_x), 42);
        ack_wait = 5; btn_r = 1'b1;
        pulse_tick();
        @(negedge clk);
        chk("pre_rst_req", 32'(wall_req), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_req", 32'(wall_req), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_pos_x", 32'(pos_x), 40);
        chk("mid_rst_pos_y", 32'(pos_y), 250);
        chk("mid_rst_count", 32'(move_count), 32'h0000);
        chk("mid_rst_wall_x", 32'(wall_x), 0);
        reset = 1'b0; btn_r = 1'b0;
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
